pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the word-aligned PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 next_pc  input  32  SHALL be the redirect target, driven by the 32-bit 2:1 next-PC mux output.
REQ-005 redirect  input  1  SHALL mean next_pc is a taken branch/jump and must replace the sequential PC.
REQ-006 halt  input  1  SHALL request a stop at the next instruction acceptance.
REQ-007 instr_ready  input  1  SHALL mean the decode stage accepts instr this cycle.
REQ-008 imem_ready  input  1  SHALL mean imem_rdata is valid for the current request.
REQ-009 imem_rdata  input  32  SHALL be the instruction word returned by memory.
REQ-010 imem_req  output  1  SHALL request a fetch at imem_addr.
REQ-011 imem_addr  output  32  SHALL equal pc while imem_req is high.
REQ-012 pc  output  32  SHALL be the address of the instruction in flight or held.
REQ-013 pc_plus4  output  32  SHALL be pc+4, combinational, feeding the next-PC mux sequential input.
REQ-014 instr  output  32  SHALL be the held instruction word.
REQ-015 instr_valid  output  1  SHALL qualify instr.
REQ-016 halted  output  1  SHALL be high only in state HALTED.

Function
REQ-017 States SHALL be IDLE, FETCH, HOLD, HALTED, registered, one-hot or binary at implementer's choice.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-019 FETCH SHALL drive imem_req=1, imem_addr=pc, instr_valid=0.
REQ-020 FETCH with imem_ready=1 and redirect=0 SHALL register instr<=imem_rdata, instr_valid<=1, go HOLD (fetch latency = memory latency + 1 cycle).
REQ-021 FETCH with redirect=1 SHALL load pc<=next_pc, discard any same-cycle imem_rdata, remain in FETCH.
REQ-022 HOLD SHALL keep instr, pc stable and instr_valid=1, imem_req=0 until instr_ready=1.
REQ-023 HOLD with instr_ready=1 SHALL load pc<=redirect ? next_pc : pc_plus4, clear instr_valid, go FETCH.
REQ-024 HOLD with instr_ready=1 and halt=1 SHALL go HALTED; pc SHALL still update per REQ-023.
REQ-025 HOLD with redirect=1 and instr_ready=0 SHALL load pc<=next_pc, drop held instr (instr_valid<=0), go FETCH.
REQ-026 halt outside an accepting HOLD cycle SHALL be ignored (not latched).
REQ-027 HALTED SHALL be sticky until reset: imem_req=0, instr_valid=0, pc frozen, redirect ignored.
REQ-028 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-029 next_pc[1:0] SHALL be ignored; loaded pc[1:0] SHALL always be 2'b00.

Reset
REQ-030 Reset SHALL act immediately, including mid-fetch: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0.
REQ-031 A memory response arriving during or the cycle after reset SHALL be discarded.

Structure
REQ-032 State encoding and RESET_PC default SHALL live in the shared processor package alongside opcode constants.
REQ-033 No sub-modules; the pc+4 adder SHALL be inline; the external 32-bit 2:1 mux SHALL remain outside this block.

Verification
REQ-034 Reset release, imem_ready one cycle after each req, instr_ready=1 -> imem_addr 0,4,8 on successive fetches; first instr_valid 3 cycles after release.
REQ-035 In HOLD at pc=0x10, redirect=1, next_pc=0x43, instr_ready=1 -> pc=0x40, next imem_addr=0x40.
REQ-036 In FETCH, redirect=1 (next_pc=0x80) same cycle as imem_ready=1 with data 0xDEADBEEF -> data dropped, instr_valid stays 0, refetch at 0x80.
REQ-037 instr_ready held 0 for 5 cycles in HOLD -> instr, pc unchanged, imem_req=0 throughout.
REQ-038 pc=0xFFFF_FFFC accepted without redirect -> pc=0x0000_0000.
REQ-039 halt=1 with instr_ready=1 -> halted=1 next cycle, no further imem_req; rst low mid-FETCH -> pc=RESET_PC, imem_req=0 asynchronously.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared processor definitions: fetch FSM states, reset PC, opcodes.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALTED
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_IMM    = 7'b001_0011;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_REG    = 7'b011_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch FSM with decode-side
// valid/ready hold, redirect and sticky halt.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        halt,
  input  logic        instr_ready,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted
);

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  target;
  logic         unused_lsb;

  // Redirect targets are forced word aligned.
  assign target     = {next_pc[31:2], 2'b00};
  assign unused_lsb = ^next_pc[1:0];
  assign pc_plus4   = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RST_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          pc_d = target;
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = redirect ? target : pc_plus4;
          state_d = halt ? S_HALTED : S_FETCH;
        end else if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_HOLD);
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit against
// an address-stream reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc = '0;
  logic        redirect = 1'b0;
  logic        halt = 1'b0;
  logic        instr_ready = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;

  pc_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .next_pc(next_pc),
    .redirect(redirect),
    .halt(halt),
    .instr_ready(instr_ready),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .instr(instr),
    .instr_valid(instr_valid),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  logic [63:0] sb_q[$];
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_idle;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_pc     = RST_PC;
    m_halted = 1'b0;
    m_idle   = 1'b1;
    sb_q.push_back({RST_PC, mem_word(RST_PC)});
  endtask

  // Monitor: samples at negedge, pops the scoreboard on each accept.
  always @(negedge clk) begin
    logic [63:0] e;
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("halted", 32'(halted), 32'(m_halted));
    if (!rst) begin
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
    end else begin
      if (imem_req) chk("imem_addr", imem_addr, pc);
      if (m_idle) chk("idle_req", 32'(imem_req), 32'h0);
      else if (m_halted) begin
        chk("halt_req", 32'(imem_req), 32'h0);
        chk("halt_valid", 32'(instr_valid), 32'h0);
      end else begin
        chk("req_vs_valid", 32'(imem_req), 32'(!instr_valid));
      end
      if (instr_valid) chk("hold_instr", instr, mem_word(pc));
      if (instr_valid && instr_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept_unexpected: got pc %h expected none", pc);
        end else begin
          e = sb_q.pop_front();
          chk("acc_pc", pc, e[63:32]);
          chk("acc_instr", instr, e[31:0]);
          n_acc++;
        end
      end
    end
  end

  // Driver and model update: one step per cycle, #1 after posedge.
  initial begin
    bit          p_rst = 1'b0;
    bit          p_redirect = 1'b0;
    bit          p_halt = 1'b0;
    bit          p_acc = 1'b0;
    bit          p_req = 1'b0;
    logic [31:0] p_next = '0;
    logic [31:0] fa[$];
    bit          seen_valid = 1'b0;
    int          rst_cnt = 0;
    int          halt_cnt = 0;
    int          r;

    model_reset();
    #1;
    chk("init_pc", pc, RST_PC);
    chk("init_instr", instr, 32'h0);
    chk("init_valid", 32'(instr_valid), 32'h0);
    chk("init_req", 32'(imem_req), 32'h0);
    chk("init_halted", 32'(halted), 32'h0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      if (p_rst && !m_halted) begin
        if (m_idle) m_idle = 1'b0;
        else if (p_acc || p_redirect) begin
          m_pc = p_redirect ? {p_next[31:2], 2'b00} : m_pc + 32'd4;
          sb_q.delete();
          if (p_acc && p_halt) m_halted = 1'b1;
          else sb_q.push_back({m_pc, mem_word(m_pc)});
        end
      end

      if (cyc < 20) begin
        if (cyc == 3) rst = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        halt        = 1'b0;
        imem_ready  = imem_req && p_req;
        imem_rdata  = imem_ready ? mem_word(imem_addr) : $urandom;
        if (imem_ready) fa.push_back(imem_addr);
        if (cyc > 3 && !seen_valid && instr_valid) begin
          seen_valid = 1'b1;
          chk("first_valid_lat", 32'(cyc - 3), 32'd3);
        end
      end else begin
        if (cyc == 20) begin
          if (fa.size() < 3) begin
            n_cmp++;
            n_bad++;
            $display("FAIL seq_fetch: got %0d fetches expected 3", fa.size());
          end else begin
            chk("seq_addr0", fa[0], 32'h0);
            chk("seq_addr1", fa[1], 32'h4);
            chk("seq_addr2", fa[2], 32'h8);
          end
        end
        if (!rst) begin
          rst_cnt++;
          if (rst_cnt >= 2) rst = 1'b1;
        end else begin
          if (m_halted) halt_cnt++;
          if (halt_cnt > 8 || ($urandom % 150) == 0) begin
            #2;
            rst = 1'b0;
            model_reset();
            #1;
            chk("async_rst_req", 32'(imem_req), 32'h0);
            chk("async_rst_pc", pc, RST_PC);
            rst_cnt  = 0;
            halt_cnt = 0;
          end
        end
        instr_ready = ($urandom % 2) == 0;
        redirect    = ($urandom % 6) == 0;
        halt        = ($urandom % 25) == 0;
        r = $urandom % 8;
        case (r)
          0: next_pc = 32'hFFFF_FFFF;
          1: next_pc = 32'hFFFF_FFFC;
          2: next_pc = 32'h0000_0043;
          3: next_pc = 32'h0000_0080;
          default: next_pc = $urandom;
        endcase
        imem_ready = ($urandom % 3) == 0;
        imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
      end

      p_rst      = rst;
      p_redirect = redirect;
      p_halt     = halt;
      p_next     = next_pc;
      p_acc      = instr_valid && instr_ready;
      p_req      = imem_req;
    end

    chk("accept_count_min", 32'(n_acc >= 50), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
